audio_pwm_out: RTL and testbench
================================

// Module: audio_pwm_out
// PURPOSE
// - Multi-channel PWM audio DAC: one PWM pin per channel, duty set by a signed sample.
// - Samples arrive on a valid/ready stream and are double-buffered.
// - Active duty changes only on a PWM period boundary, so every period is glitch-free.
// - Sits between the waveform generator/mixer and the board audio PWM pins.
// PARAMETERS
// - WIDTH     8   sample/counter width; PWM period = 2**WIDTH ticks
// - NUM_CH    2   channel count; one duty register and one output bit per channel
// - PRESCALE  1   clk cycles per counter tick (>=1); sets PWM carrier = clk/(PRESCALE*2**WIDTH)
// PORTS
// - clk           in   1               system clock, all logic on rising edge
// - rst_n         in   1               asynchronous, active-low reset
// - in_data       in   NUM_CH*WIDTH    signed two's-complement samples, ch k at [k*WIDTH +: WIDTH]
// - in_valid      in   1               in_data valid
// - in_ready      out  1               holding buffer empty; transfer on in_valid && in_ready
// - mute          in   1               force silence (midscale) from next period
// - pwm_out       out  NUM_CH          PWM pins, registered
// - period_start  out  1               1-cycle pulse: new period began, duties loaded
// - underrun      out  1               1-cycle pulse: boundary reached with no pending sample
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - prescaler=0, count=0, pending empty, active duty = 2**(WIDTH-1) all ch
//   - pwm_out=0, in_ready=1, period_start=0, underrun=0
// - tick = (prescaler==PRESCALE-1); prescaler wraps to 0 on tick.
//   - count += 1 on tick, wraps 2**WIDTH-1 -> 0.
// - boundary = tick && count==2**WIDTH-1.
// - Input:
//   - accept stores in_data to pending, pending full; in_ready = !pending_full (registered).
// - On boundary:
//   - mute=1: active = midscale all ch; pending (if full) consumed and discarded.
//   - else if pending full: active = pending converted; pending emptied (in_ready=1 next cycle).
//   - else: active held (repeat last duty); underrun pulses next cycle.
//   - period_start pulses the cycle after boundary in all cases.
// - Accept on the boundary cycle with pending empty:
//   - sample lands in pending for the NEXT boundary.
//   - underrun still pulses; no bypass to active.
// - Conversion: duty = {~s[WIDTH-1], s[WIDTH-2:0]} (offset binary).
//   - 0 -> 50%; max +ve -> (2**WIDTH-1)/2**WIDTH; min -ve -> 0%. Never 100%.
// - pwm_out[k] <= (count < active[k]) ? HIGH : 1'b0, every clk; 1-cycle latency from count.
// - Channels are phase-aligned (shared counter); no cross-channel interaction.
// - Reset mid-period: immediate return to reset state; pending sample lost.
// CONFIGURATION
// - AUDIO_PWM_OPEN_DRAIN_EN defined: HIGH = 1'bz (open-drain, external pull-up), low driven 0.
// - AUDIO_PWM_OPEN_DRAIN_EN undefined: HIGH = 1'b1 (push-pull).
// - Reset value 1'b0 in both builds.
// TESTING (WIDTH=8, NUM_CH=2, PRESCALE=1 unless stated)
// - Reset: rst_n=0 mid-period -> pwm_out=0, in_ready=1, period_start=0, underrun=0 immediately.
// - Duty: ch0=8'h00, ch1=8'h40 -> per 256-clk period, ch0 high 128 clks, ch1 high 192 clks.
// - Extremes: ch0=8'h7F, ch1=8'h80 -> ch0 high 255/256, ch1 never high; open-drain build: high level reads z.
// - Backpressure: two samples back-to-back -> 2nd held (in_ready=0) until boundary.
//   - 2nd accepted cycle after period_start; applied one period later.
// - Underrun: no sample for 3 periods -> underrun pulses 3x, duty repeats last value.
// - Mute/prescale: PRESCALE=4, mute=1, data 8'h7F -> period 1024 clks, 512 high; pending consumed.

Source files
------------

// File: rtl/audio_pwm_out_if.sv
// -----------------------------------------------------------------------------
// audio_pwm_out_if
// Purpose : sample stream into the PWM audio DAC (valid/ready handshake).
//           A transfer happens on a rising clk edge where in_valid && in_ready.
// Signals : in_data  [NUM_CH*WIDTH] signed samples, channel k at [k*WIDTH +: WIDTH]
//           in_valid                source has a sample on in_data
//           in_ready                sink holding buffer is empty
// Modports: master = sample source, slave = audio_pwm_out
// -----------------------------------------------------------------------------
interface audio_pwm_out_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 2
);
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic                    in_valid;
   logic                    in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// -----------------------------------------------------------------------------
// audio_pwm_out
// Purpose : multi-channel PWM audio DAC. Each channel drives one PWM pin whose
//           duty follows a signed sample. Samples arrive on a valid/ready stream
//           into a one-entry holding buffer and are moved into the active duty
//           registers only on a PWM period boundary, so no period is ever cut.
// Params  : WIDTH    sample/counter width, period = 2**WIDTH ticks
//           NUM_CH   number of channels / PWM pins
//           PRESCALE clk cycles per counter tick (>=1)
// Ports   : clk          system clock (rising edge)
//           rst_n        asynchronous active-low reset
//           in_if        slave side of the sample stream (audio_pwm_out_if)
//           mute         load midscale (silence) at the next boundary
//           pwm_out      PWM pins, registered
//           period_start 1-cycle pulse: a new period began, duties loaded
//           underrun     1-cycle pulse: boundary reached with no pending sample
// Build   : define AUDIO_PWM_OPEN_DRAIN_EN for open-drain pins (high level is
//           released to z for an external pull-up); otherwise push-pull.
// -----------------------------------------------------------------------------
module audio_pwm_out #(
   parameter int WIDTH    = 8,
   parameter int NUM_CH   = 2,
   parameter int PRESCALE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   audio_pwm_out_if.slave       in_if,
   input  logic                 mute,
   output logic [NUM_CH-1:0]    pwm_out,
   output logic                 period_start,
   output logic                 underrun
);
   localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

   logic [PS_W-1:0]          r_prescale;
   logic [WIDTH-1:0]         r_count;
   logic [NUM_CH*WIDTH-1:0]  r_pending;
   logic                     r_pend_full;
   logic                     r_in_ready;
   logic                     r_period_start;
   logic                     r_underrun;

   logic                     w_tick;
   logic                     w_boundary;
   logic                     w_accept;

   assign w_tick     = (r_prescale == PS_LAST);
   assign w_boundary = w_tick && (r_count == {WIDTH{1'b1}});
   // in_ready is the registered inverse of pending-full, so accept and
   // boundary-consume can never hit the same cycle with pending full.
   assign w_accept   = in_if.in_valid && r_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale     <= '0;
         r_count        <= '0;
         r_pending      <= '0;
         r_pend_full    <= 1'b0;
         r_in_ready     <= 1'b1;
         r_period_start <= 1'b0;
         r_underrun     <= 1'b0;
      end else begin
         r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
         if (w_tick) begin
            r_count <= r_count + 1'b1;
         end

         r_period_start <= w_boundary;
         // Muted boundaries are intentional silence, not starvation.
         r_underrun     <= w_boundary && !mute && !r_pend_full;

         if (w_accept) begin
            // A sample taken on an empty boundary waits for the next one.
            r_pending   <= in_if.in_data;
            r_pend_full <= 1'b1;
            r_in_ready  <= 1'b0;
         end else if (w_boundary && r_pend_full) begin
            // Consumed by the boundary, whether loaded or discarded by mute.
            r_pend_full <= 1'b0;
            r_in_ready  <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] w_sample;
         logic [WIDTH-1:0] w_duty;
         logic [WIDTH-1:0] r_active;
         logic             r_pwm_hi;

         assign w_sample = r_pending[gi*WIDTH +: WIDTH];
         // Two's complement to offset binary: flip the sign bit.
         assign w_duty   = {~w_sample[WIDTH-1], w_sample[WIDTH-2:0]};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_active <= MIDSCALE;
               r_pwm_hi <= 1'b0;
            end else begin
               if (w_boundary) begin
                  if (mute) begin
                     r_active <= MIDSCALE;
                  end else if (r_pend_full) begin
                     r_active <= w_duty;
                  end
               end
               // Strict compare: duty 2**WIDTH-1 stays high all but one tick.
               r_pwm_hi <= (r_count < r_active);
            end
         end

`ifdef AUDIO_PWM_OPEN_DRAIN_EN
         assign pwm_out[gi] = r_pwm_hi ? 1'bz : 1'b0;
`else
         assign pwm_out[gi] = r_pwm_hi;
`endif
      end
   endgenerate

   assign in_if.in_ready = r_in_ready;
   assign period_start   = r_period_start;
   assign underrun       = r_underrun;
endmodule

// File: tb/tb_audio_pwm_out.sv
module tb_audio_pwm_out;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

`ifdef AUDIO_PWM_OPEN_DRAIN_EN
   localparam logic HI = 1'bz;
`else
   localparam logic HI = 1'b1;
`endif

   audio_pwm_out_if #(.WIDTH(8), .NUM_CH(2)) if_a ();
   audio_pwm_out_if #(.WIDTH(8), .NUM_CH(2)) if_b ();

   logic       mute_a = 1'b0;
   logic       mute_b = 1'b0;
   logic [1:0] pwm_a, pwm_b;
   logic       ps_a, uf_a, ps_b, uf_b;

   audio_pwm_out #(.WIDTH(8), .NUM_CH(2), .PRESCALE(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_if(if_a), .mute(mute_a),
      .pwm_out(pwm_a), .period_start(ps_a), .underrun(uf_a));

   audio_pwm_out #(.WIDTH(8), .NUM_CH(2), .PRESCALE(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_if(if_b), .mute(mute_b),
      .pwm_out(pwm_b), .period_start(ps_b), .underrun(uf_b));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;   // {ch1, ch0}
      logic        mute;
      int          hi0;
      int          hi1;
   } vec_t;
   vec_t vecs [4];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Wait for a period_start pulse, bounded; ends on the pulse's negedge.
   task automatic wait_ps(input bit b, input int limit, input string name);
      int found;
      found = 0;
      for (int n = 0; n < limit && found == 0; n++) begin
         @(negedge clk);
         if ((b ? ps_b : ps_a) === 1'b1) found = 1;
      end
      check(name, found, 1);
   endtask

   // Run len cycles starting just after a period_start negedge; counts high
   // samples per channel, pulses, and cycles with in_ready low.
   task automatic run_per(input bit b, input int len,
                          output int hi0, output int hi1, output int ps_n,
                          output int uf_n, output int busy_n);
      logic [1:0] p;
      hi0 = 0; hi1 = 0; ps_n = 0; uf_n = 0; busy_n = 0;
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         if (b) if_b.in_valid = 1'b0; else if_a.in_valid = 1'b0;
         p = b ? pwm_b : pwm_a;
         if (p[0] === HI) hi0++;
         if (p[1] === HI) hi1++;
         if ((b ? ps_b : ps_a) === 1'b1) ps_n++;
         if ((b ? uf_b : uf_a) === 1'b1) uf_n++;
         if ((b ? if_b.in_ready : if_a.in_ready) !== 1'b1) busy_n++;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " pwm_a"},   int'(pwm_a), 0);
      check({tag, " ready_a"}, int'(if_a.in_ready), 1);
      check({tag, " ps_a"},    int'(ps_a), 0);
      check({tag, " uf_a"},    int'(uf_a), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi0, hi1, ps_n, uf_n, busy_n, busy;

      vecs[0] = '{data: 16'h4000, mute: 1'b0, hi0: 128, hi1: 192};
      vecs[1] = '{data: 16'h4000, mute: 1'b1, hi0: 128, hi1: 128};
      vecs[2] = '{data: 16'h807F, mute: 1'b0, hi0: 255, hi1: 0};
      vecs[3] = '{data: 16'h01C0, mute: 1'b0, hi0: 64,  hi1: 129};

      if_a.in_data = '0; if_a.in_valid = 1'b0;
      if_b.in_data = '0; if_b.in_valid = 1'b0;

      // Asynchronous reset between clock edges.
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // First boundary after reset: nothing pending, midscale duty.
      wait_ps(1'b0, 300, "first period_start");
      check("first underrun", int'(uf_a), 1);
      run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
      check("midscale hi0", hi0, 128);
      check("midscale hi1", hi1, 128);
      check("midscale uf", uf_n, 1);

      // Table: load one sample per two periods and measure its duty.
      for (int i = 0; i < 4; i++) begin
         mute_a        = vecs[i].mute;
         if_a.in_data  = vecs[i].data;
         if_a.in_valid = 1'b1;
         run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
         check($sformatf("v%0d busy", i), busy_n, 255);
         check($sformatf("v%0d ps", i), ps_n, 1);
         check($sformatf("v%0d uf load", i), uf_n, 0);
         mute_a = 1'b0;
         run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
         check($sformatf("v%0d hi0", i), hi0, vecs[i].hi0);
         check($sformatf("v%0d hi1", i), hi1, vecs[i].hi1);
         check($sformatf("v%0d uf idle", i), uf_n, 1);
      end

      // Underrun: three empty periods repeat the last duty.
      for (int i = 0; i < 3; i++) begin
         run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
         check($sformatf("ur%0d uf", i), uf_n, 1);
         check($sformatf("ur%0d hi0", i), hi0, 64);
         check($sformatf("ur%0d hi1", i), hi1, 129);
      end

      // Backpressure: second sample held until the boundary frees the buffer.
      if_a.in_data  = 16'h4000;
      if_a.in_valid = 1'b1;
      @(negedge clk);
      check("bp ready after 1st", int'(if_a.in_ready), 0);
      if_a.in_data = 16'h807F;
      busy = 0;
      for (int n = 2; n <= 256; n++) begin
         @(negedge clk);
         if (if_a.in_ready !== 1'b1) busy++;
      end
      check("bp busy cycles", busy, 254);
      check("bp ready at boundary", int'(if_a.in_ready), 1);
      check("bp ps at boundary", int'(ps_a), 1);
      run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
      check("bp 1st hi0", hi0, 128);
      check("bp 1st hi1", hi1, 192);
      check("bp 2nd held", busy_n, 255);
      check("bp 1st uf", uf_n, 0);
      run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
      check("bp 2nd hi0", hi0, 255);
      check("bp 2nd hi1", hi1, 0);

      // Mid-period reset with a sample pending and ch0 high.
      if_a.in_data  = 16'h1111;
      if_a.in_valid = 1'b1;
      run_per(1'b0, 100, hi0, hi1, ps_n, uf_n, busy_n);
      check("pre-reset ch0 high", int'(pwm_a[0] === HI), 1);
      check("pre-reset ready", int'(if_a.in_ready), 0);
      #2 rst_n = 1'b0;
      #1 check_reset("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      wait_ps(1'b0, 300, "post-reset period_start");
      check("post-reset uf (pending lost)", int'(uf_a), 1);
      run_per(1'b0, 256, hi0, hi1, ps_n, uf_n, busy_n);
      check("post-reset hi0", hi0, 128);
      check("post-reset hi1", hi1, 128);

      // PRESCALE=4 instance with mute: sample consumed, midscale loaded.
      wait_ps(1'b1, 1100, "b period_start");
      mute_b        = 1'b1;
      if_b.in_data  = 16'h7F7F;
      if_b.in_valid = 1'b1;
      run_per(1'b1, 1024, hi0, hi1, ps_n, uf_n, busy_n);
      check("b ps per 1024", ps_n, 1);
      check("b busy", busy_n, 1023);
      check("b uf muted", uf_n, 0);
      check("b ready after consume", int'(if_b.in_ready), 1);
      run_per(1'b1, 1024, hi0, hi1, ps_n, uf_n, busy_n);
      check("b hi0", hi0, 512);
      check("b hi1", hi1, 512);
      check("b ps 2nd", ps_n, 1);
      mute_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
